// File: rtl/paint_scheduler.sv
// paint_scheduler: buffers brush commands and expands them into clipped pixel writes issued only during VGA blanking.
// Define PAINT_CLEAR_EN to add the cmd_clear port and the full-screen CLEAR sweep.
module paint_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x,
  input  logic [9:0] cmd_y,
  input  logic [2:0] cmd_color,
  input  logic [1:0] cmd_radius,
`ifdef PAINT_CLEAR_EN
  input  logic       cmd_clear,
`endif
  input  logic       blank_b,
  output logic       wr_en,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [2:0] wr_color,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PAINT_CLEAR_EN
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, CLEAR} state_t;
  logic [25:0] w_ent_in, w_head;
  assign w_ent_in = {cmd_clear, cmd_radius, cmd_color, cmd_y, cmd_x};
`else
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;
  logic [24:0] w_ent_in, w_head;
  assign w_ent_in = {cmd_radius, cmd_color, cmd_y, cmd_x};
`endif
  logic [$bits(w_ent_in)-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt, w_ncnt;
  logic r_rdy, w_full, w_push, w_pop;
  state_t r_st;
  logic signed [10:0] r_x, r_y, r_x0, r_xe, r_ye;
  logic [10:0] w_cx, w_cy, w_r;
  logic [2:0] r_col;
  logic w_in, w_go;
  assign w_full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign cmd_ready = r_rdy && !w_full;
  assign w_push = cmd_valid && cmd_ready;
  assign w_pop = r_st == LOAD;
  assign w_ncnt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_head = r_mem[r_rp];
  assign w_cx = {1'b0, w_head[9:0]};
  assign w_cy = {1'b0, w_head[19:10]};
  assign w_r = {9'b0, w_head[24:23]};
  assign w_in = int'(r_x) >= 0 && int'(r_x) < H_RES && int'(r_y) >= 0 && int'(r_y) < V_RES;
  // Off-screen points never wait for blanking; on-screen points stall until blank_b drops.
  assign w_go = !w_in || !blank_b;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      r_cnt <= w_ncnt;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= w_ent_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_st <= IDLE;
      r_x <= '0;
      r_y <= '0;
      r_x0 <= '0;
      r_xe <= '0;
      r_ye <= '0;
      r_col <= '0;
      wr_en <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
      wr_color <= '0;
      busy <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      busy <= 1'b1;
      case (r_st)
        IDLE: if (w_ncnt != '0) r_st <= LOAD; else busy <= 1'b0;
        LOAD: begin
          r_x <= w_cx - w_r;
          r_x0 <= w_cx - w_r;
          r_xe <= w_cx + w_r;
          r_y <= w_cy - w_r;
          r_ye <= w_cy + w_r;
          r_col <= w_head[22:20];
          r_st <= SWEEP;
`ifdef PAINT_CLEAR_EN
          if (w_head[25]) begin
            r_x <= '0;
            r_x0 <= '0;
            r_xe <= 11'(H_RES - 1);
            r_y <= '0;
            r_ye <= 11'(V_RES - 1);
            r_col <= '0;
            r_st <= CLEAR;
          end
`endif
        end
        default: if (w_go) begin
          wr_en <= w_in;
          if (w_in) begin
            wr_x <= r_x[9:0];
            wr_y <= r_y[9:0];
            wr_color <= r_col;
          end
          if (r_x != r_xe) r_x <= r_x + 11'sd1;
          else if (r_y != r_ye) begin
            r_x <= r_x0;
            r_y <= r_y + 11'sd1;
          end else begin
            r_st <= IDLE;
            busy <= w_ncnt != '0;
          end
        end
      endcase
    end
endmodule
